// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_ctrl_pkg                                                   |
// | State encodings, strobe bit positions and cycle-count helpers.   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam int STB_CLR     = 0;
  localparam int STB_INC_SEC = 1;
  localparam int STB_INC_MIN = 2;
  localparam int STB_DEC_SEC = 3;
  localparam int STB_W       = 4;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return int'((longint'(clk_hz) * longint'(ms)) / 1000);
  endfunction

  function automatic int hz_to_cycles(input int clk_hz, input int hz);
    return clk_hz / hz;
  endfunction

  // Bits needed to hold 0 .. n-1
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_ctrl_btn_press.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_ctrl_btn_press                                             |
// | Button press edge detect with optional hold-to-repeat timer      |
// | (repeat built when REPEAT_EN=1, driven by AUTO_REPEAT_EN).       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module timer_ctrl_btn_press
  import timer_ctrl_pkg::*;
#(
  parameter bit REPEAT_EN  = 1'b0,
  parameter int DELAY_CYC  = 500,
  parameter int PERIOD_CYC = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic rpt_cancel,
  output logic press,
  output logic rpt
);

  logic r_btn_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_btn_prev <= 1'b1;
    else        r_btn_prev <= btn_n;
  end

  assign press = r_btn_prev & ~btn_n;

  generate
    if (REPEAT_EN) begin : g_rpt
      localparam int CW = cnt_width((DELAY_CYC > PERIOD_CYC) ? DELAY_CYC : PERIOD_CYC);
      localparam logic [CW-1:0] C_DELAY_LAST  = CW'(DELAY_CYC - 1);
      localparam logic [CW-1:0] C_PERIOD_LAST = CW'(PERIOD_CYC - 1);

      logic [CW-1:0] r_cnt;
      logic          r_armed;
      logic          r_repeating;
      logic          w_fire;

      // A cancelled hold stays disarmed until the button is released and pressed again
      assign w_fire = r_armed & ~btn_n & ~rpt_cancel &
                      (r_repeating ? (r_cnt == C_PERIOD_LAST) : (r_cnt == C_DELAY_LAST));
      assign rpt = w_fire;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt       <= '0;
          r_armed     <= 1'b0;
          r_repeating <= 1'b0;
        end else if (rpt_cancel || btn_n) begin
          r_cnt       <= '0;
          r_armed     <= 1'b0;
          r_repeating <= 1'b0;
        end else if (press) begin
          r_cnt       <= '0;
          r_armed     <= 1'b1;
          r_repeating <= 1'b0;
        end else if (r_armed) begin
          if (w_fire) begin
            r_cnt       <= '0;
            r_repeating <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end else begin : g_no_rpt
      logic w_unused;
      assign w_unused = ^{rpt_cancel, DELAY_CYC[0], PERIOD_CYC[0]};
      assign rpt      = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_ctrl                                                       |
// | mm:ss countdown sequencer: button commands, run/pause, alarm.    |
// | Define AUTO_REPEAT_EN to build hold-to-repeat on SEC/MIN.        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = 25175000,
  parameter int ALARM_SECS      = 10,
  parameter int BLINK_HZ        = 2,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_HZ  = 8
) (
  input  logic       MCLK,
  input  logic       RESET_N,
  input  logic       BT_START_N,
  input  logic       BT_CLR_N,
  input  logic       BT_SEC_N,
  input  logic       BT_MIN_N,
  input  logic       TICK_1HZ,
  input  logic       CNT_ZERO,
  output logic       CNT_CLR,
  output logic       CNT_INC_SEC,
  output logic       CNT_INC_MIN,
  output logic       CNT_DEC_SEC,
  output logic       RUNNING,
  output logic       ALARM,
  output logic [1:0] STATE
);

`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam int DELAY_CYC  = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int PERIOD_CYC = hz_to_cycles(CLK_HZ, REPEAT_RATE_HZ);
  localparam int BLINK_HALF = hz_to_cycles(CLK_HZ, 2 * BLINK_HZ);
  localparam int BW         = cnt_width(BLINK_HALF);
  localparam int AW         = cnt_width(ALARM_SECS);
  localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [AW-1:0] C_ALARM_LAST = AW'(ALARM_SECS - 1);

  state_t           r_state;
  logic [STB_W-1:0] r_strobe;
  logic             r_running;
  logic             r_alarm;
  logic [BW-1:0]    r_blink_cnt;
  logic [AW-1:0]    r_alarm_cnt;

  logic w_press_start, w_press_clr, w_press_sec, w_press_min;
  logic w_rpt_start, w_rpt_clr, w_rpt_sec, w_rpt_min;
  logic w_act_sec, w_act_min, w_press_any;
  logic w_cancel_sec, w_cancel_min;
  logic w_unused_rpt;

  // A repeat is cancelled by leaving IDLE or by any higher-priority press
  assign w_cancel_sec = (r_state != ST_IDLE) | w_press_clr | w_press_start;
  assign w_cancel_min = w_cancel_sec | w_press_sec | w_rpt_sec;

  timer_ctrl_btn_press #(.REPEAT_EN(1'b0), .DELAY_CYC(DELAY_CYC), .PERIOD_CYC(PERIOD_CYC)) u_btn_start (
    .clk(MCLK), .rst_n(RESET_N), .btn_n(BT_START_N), .rpt_cancel(1'b1),
    .press(w_press_start), .rpt(w_rpt_start)
  );

  timer_ctrl_btn_press #(.REPEAT_EN(1'b0), .DELAY_CYC(DELAY_CYC), .PERIOD_CYC(PERIOD_CYC)) u_btn_clr (
    .clk(MCLK), .rst_n(RESET_N), .btn_n(BT_CLR_N), .rpt_cancel(1'b1),
    .press(w_press_clr), .rpt(w_rpt_clr)
  );

  timer_ctrl_btn_press #(.REPEAT_EN(REPEAT_EN), .DELAY_CYC(DELAY_CYC), .PERIOD_CYC(PERIOD_CYC)) u_btn_sec (
    .clk(MCLK), .rst_n(RESET_N), .btn_n(BT_SEC_N), .rpt_cancel(w_cancel_sec),
    .press(w_press_sec), .rpt(w_rpt_sec)
  );

  timer_ctrl_btn_press #(.REPEAT_EN(REPEAT_EN), .DELAY_CYC(DELAY_CYC), .PERIOD_CYC(PERIOD_CYC)) u_btn_min (
    .clk(MCLK), .rst_n(RESET_N), .btn_n(BT_MIN_N), .rpt_cancel(w_cancel_min),
    .press(w_press_min), .rpt(w_rpt_min)
  );

  assign w_unused_rpt = w_rpt_start | w_rpt_clr;
  assign w_act_sec    = w_press_sec | w_rpt_sec;
  assign w_act_min    = w_press_min | w_rpt_min;
  assign w_press_any  = w_press_start | w_press_clr | w_press_sec | w_press_min;

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_strobe    <= '0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
      r_blink_cnt <= '0;
      r_alarm_cnt <= '0;
    end else begin
      r_strobe <= '0;
      case (r_state)
        ST_IDLE: begin
          r_running   <= 1'b0;
          r_alarm     <= 1'b0;
          r_blink_cnt <= '0;
          r_alarm_cnt <= '0;
          if (w_press_clr) begin
            r_strobe[STB_CLR] <= 1'b1;
          end else if (w_press_start) begin
            if (!CNT_ZERO) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end else if (w_act_sec) begin
            r_strobe[STB_INC_SEC] <= 1'b1;
          end else if (w_act_min) begin
            r_strobe[STB_INC_MIN] <= 1'b1;
          end
        end

        ST_RUN: begin
          if (w_press_start) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (CNT_ZERO) begin
            r_state     <= ST_EXPIRED;
            r_running   <= 1'b0;
            r_alarm     <= 1'b1;
            r_blink_cnt <= '0;
            r_alarm_cnt <= '0;
          end else if (TICK_1HZ) begin
            r_strobe[STB_DEC_SEC] <= 1'b1;
          end
        end

        ST_EXPIRED: begin
          if (w_press_any || (TICK_1HZ && (r_alarm_cnt == C_ALARM_LAST))) begin
            r_state <= ST_IDLE;
            r_alarm <= 1'b0;
          end else begin
            if (TICK_1HZ) r_alarm_cnt <= r_alarm_cnt + AW'(1);
            if (r_blink_cnt == C_BLINK_LAST) begin
              r_blink_cnt <= '0;
              r_alarm     <= ~r_alarm;
            end else begin
              r_blink_cnt <= r_blink_cnt + BW'(1);
            end
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_alarm   <= 1'b0;
        end
      endcase
    end
  end

  assign CNT_CLR     = r_strobe[STB_CLR];
  assign CNT_INC_SEC = r_strobe[STB_INC_SEC];
  assign CNT_INC_MIN = r_strobe[STB_INC_MIN];
  assign CNT_DEC_SEC = r_strobe[STB_DEC_SEC];
  assign RUNNING     = r_running;
  assign ALARM       = r_alarm;
  assign STATE       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_timer_ctrl                                                    |
// | Directed bench for timer_ctrl with a behavioural counter model.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_timer_ctrl;

  localparam int TICK_PERIOD = 1000;
  localparam logic [3:0] B_NONE = 4'b0000, B_START = 4'b1000, B_CLR = 4'b0100,
                         B_SEC = 4'b0010, B_MIN = 4'b0001;
`ifdef AUTO_REPEAT_EN
  localparam int EXP_HOLD_STROBES = 13;
`else
  localparam int EXP_HOLD_STROBES = 1;
`endif

  logic MCLK, RESET_N, BT_START_N, BT_CLR_N, BT_SEC_N, BT_MIN_N, TICK_1HZ, CNT_ZERO;
  logic CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC_SEC, RUNNING, ALARM;
  logic [1:0] STATE;

  timer_ctrl #(
    .CLK_HZ(1000), .ALARM_SECS(10), .BLINK_HZ(2), .REPEAT_DELAY_MS(500), .REPEAT_RATE_HZ(8)
  ) dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .BT_START_N(BT_START_N), .BT_CLR_N(BT_CLR_N),
    .BT_SEC_N(BT_SEC_N), .BT_MIN_N(BT_MIN_N), .TICK_1HZ(TICK_1HZ), .CNT_ZERO(CNT_ZERO),
    .CNT_CLR(CNT_CLR), .CNT_INC_SEC(CNT_INC_SEC), .CNT_INC_MIN(CNT_INC_MIN),
    .CNT_DEC_SEC(CNT_DEC_SEC), .RUNNING(RUNNING), .ALARM(ALARM), .STATE(STATE)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Behavioural mm:ss counter chain, held as total seconds
  int total = 0;
  int n_clr = 0, n_inc_sec = 0, n_inc_min = 0, n_dec = 0, multi_err = 0;
  assign CNT_ZERO = (total == 0);

  always @(posedge MCLK) begin
    if (CNT_CLR === 1'b1)          total <= 0;
    else if (CNT_INC_SEC === 1'b1) total <= (total + 1) % 6000;
    else if (CNT_INC_MIN === 1'b1) total <= (total + 60) % 6000;
    else if (CNT_DEC_SEC === 1'b1) total <= (total == 0) ? 5999 : total - 1;
    if (CNT_CLR === 1'b1)     n_clr     <= n_clr + 1;
    if (CNT_INC_SEC === 1'b1) n_inc_sec <= n_inc_sec + 1;
    if (CNT_INC_MIN === 1'b1) n_inc_min <= n_inc_min + 1;
    if (CNT_DEC_SEC === 1'b1) n_dec     <= n_dec + 1;
    if ($countones({CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC_SEC}) > 1) multi_err <= multi_err + 1;
  end

  int n_checks = 0, n_fail = 0;
  int tick_phase = 0, tick_count = 0;
  bit tick_en = 1'b0, tick_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One or more clocks; leaves the bench at #1 after the rising edge
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      TICK_1HZ = tick_force | (tick_en && (tick_phase == TICK_PERIOD - 1));
      @(posedge MCLK);
      #1;
      if (TICK_1HZ) tick_count++;
      tick_phase = (tick_phase + 1) % TICK_PERIOD;
      tick_force = 1'b0;
      TICK_1HZ   = 1'b0;
    end
  endtask

  task automatic set_btn(input logic [3:0] p);
    BT_START_N = ~p[3];
    BT_CLR_N   = ~p[2];
    BT_SEC_N   = ~p[1];
    BT_MIN_N   = ~p[0];
  endtask

  task automatic press(input logic [3:0] p, input int hold = 1);
    set_btn(p);
    cyc(hold);
    set_btn(B_NONE);
    cyc(2);
  endtask

  typedef struct packed {
    logic [3:0]  btn;       // {start, clr, sec, min} pressed
    logic [3:0]  exp_stb;   // {clr, inc_sec, inc_min, dec}
    logic [1:0]  exp_state;
    logic [12:0] exp_total;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, base, base_dec, k;
    vecs[0] = '{btn: B_SEC,               exp_stb: 4'b0100, exp_state: 2'd0, exp_total: 13'd1};
    vecs[1] = '{btn: B_MIN,               exp_stb: 4'b0010, exp_state: 2'd0, exp_total: 13'd61};
    vecs[2] = '{btn: B_SEC | B_MIN,       exp_stb: 4'b0100, exp_state: 2'd0, exp_total: 13'd62};
    vecs[3] = '{btn: B_CLR | B_SEC,       exp_stb: 4'b1000, exp_state: 2'd0, exp_total: 13'd0};
    vecs[4] = '{btn: B_START,             exp_stb: 4'b0000, exp_state: 2'd0, exp_total: 13'd0};
    vecs[5] = '{btn: B_MIN,               exp_stb: 4'b0010, exp_state: 2'd0, exp_total: 13'd60};
    vecs[6] = '{btn: B_START | B_SEC,     exp_stb: 4'b0000, exp_state: 2'd1, exp_total: 13'd60};
    vecs[7] = '{btn: 4'b1111,             exp_stb: 4'b1000, exp_state: 2'd0, exp_total: 13'd0};

    RESET_N  = 1'b0;
    TICK_1HZ = 1'b0;
    set_btn(B_NONE);

    // Reset state and quiet idle after release
    cyc(3);
    check("reset_outputs", 32'({CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC_SEC, RUNNING, ALARM, STATE}), 0);
    RESET_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if ({CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC_SEC, RUNNING, ALARM, STATE} !== 8'd0) bad++;
    end
    check("idle_quiet_cycles", 32'(bad), 0);

    // Set 01:03 and count down three seconds
    for (int i = 0; i < 3; i++) press(B_SEC);
    press(B_MIN);
    check("set_total_0103", 32'(total), 63);
    press(B_START);
    check("run_state", 32'({RUNNING, STATE}), 32'b101);
    base_dec = n_dec;
    tick_phase = 0;
    tick_en = 1'b1;
    cyc(TICK_PERIOD * 3);
    tick_en = 1'b0;
    cyc(2);
    check("dec_per_tick", 32'(n_dec - base_dec), 3);
    check("total_after_3_ticks", 32'(total), 60);
    press(B_START);
    check("pause_state", 32'({RUNNING, STATE}), 0);

    // Countdown to expiry, blink and alarm timeout
    press(B_CLR);
    press(B_SEC);
    press(B_SEC);
    check("set_total_0002", 32'(total), 2);
    press(B_START);
    base_dec = n_dec;
    tick_phase = 0;
    tick_en = 1'b1;
    for (int i = 0; i < 3000 && !CNT_ZERO; i++) cyc(1);
    check("zero_reached", 32'(CNT_ZERO), 1);
    check("still_run_at_zero", 32'(STATE), 1);
    cyc(1);
    check("expired_entry", 32'({STATE, ALARM}), 32'b101);
    base = tick_count;
    cyc(249);
    check("blink_on_phase", 32'(ALARM), 1);
    cyc(1);
    check("blink_off_phase", 32'(ALARM), 0);
    cyc(250);
    check("blink_on_again", 32'(ALARM), 1);
    k = 0;
    while (STATE != 2'd0 && k < 12000) begin
      cyc(1);
      k++;
    end
    check("alarm_timeout_idle", 32'(STATE), 0);
    check("alarm_ticks", 32'(tick_count - base), 10);
    check("alarm_off", 32'(ALARM), 0);
    check("expiry_dec_count", 32'(n_dec - base_dec), 2);
    tick_en = 1'b0;

    // START and TICK on the same cycle in RUN
    press(B_CLR);
    for (int i = 0; i < 5; i++) press(B_SEC);
    press(B_START);
    base_dec = n_dec;
    set_btn(B_START);
    tick_force = 1'b1;
    cyc(1);
    check("start_tick_state", 32'(STATE), 0);
    check("start_tick_no_dec", 32'(CNT_DEC_SEC), 0);
    set_btn(B_NONE);
    cyc(2);
    check("start_tick_total", 32'(total), 5);
    press(B_START);
    tick_force = 1'b1;
    cyc(1);
    check("tick_in_run_dec", 32'(CNT_DEC_SEC), 1);
    cyc(2);
    check("tick_in_run_total", 32'(total), 4);
    press(B_START);
    tick_force = 1'b1;
    cyc(1);
    check("tick_in_idle_no_dec", 32'(CNT_DEC_SEC), 0);
    cyc(2);

    // Table of single-cycle press patterns from IDLE
    press(B_CLR);
    for (int v = 0; v < 8; v++) begin
      set_btn(vecs[v].btn);
      cyc(1);
      check($sformatf("vec%0d_strobes", v),
            32'({CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC_SEC}), 32'(vecs[v].exp_stb));
      check($sformatf("vec%0d_state", v), 32'(STATE), 32'(vecs[v].exp_state));
      set_btn(B_NONE);
      cyc(2);
      if (vecs[v].exp_state == 2'd1) press(B_START);
      check($sformatf("vec%0d_total", v), 32'(total), 32'(vecs[v].exp_total));
    end

    // Press during EXPIRED is consumed
    press(B_SEC);
    press(B_START);
    tick_force = 1'b1;
    cyc(3);
    check("expired_by_tick", 32'(STATE), 2);
    base = n_inc_sec;
    set_btn(B_SEC);
    cyc(1);
    check("expired_press_idle", 32'(STATE), 0);
    check("expired_press_no_inc", 32'(CNT_INC_SEC), 0);
    set_btn(B_NONE);
    cyc(2);
    check("expired_press_total", 32'(n_inc_sec - base), 0);

    // Asynchronous reset in the middle of RUN
    press(B_SEC);
    press(B_START);
    #3;
    RESET_N = 1'b0;
    #1;
    check("async_reset_state", 32'({RUNNING, STATE}), 0);
    cyc(2);
    RESET_N = 1'b1;
    cyc(3);
    check("reset_keeps_total", 32'(total), 1);
    check("reset_no_restart", 32'(STATE), 0);

    // SEC held for 2000 cycles
    base = n_inc_sec;
    press(B_SEC, 2000);
    cyc(2);
    check("hold_sec_strobes", 32'(n_inc_sec - base), 32'(EXP_HOLD_STROBES));

    check("single_strobe_per_cycle", 32'(multi_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
